// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, state enums and nibble encoder for uart_hex_tx.
//   AsciiCr/AsciiLf/AsciiZero/AsciiA : ASCII codes used when rendering bytes as hex text
//   DefaultClksPerBit                : 115200 baud at 25 MHz
//   rec_state_t                      : record FSM (which character of the record is on the line)
//   ser_state_t                      : character serializer phase
package uart_pkg;

  localparam logic [7:0] AsciiCr   = 8'h0D;
  localparam logic [7:0] AsciiLf   = 8'h0A;
  localparam logic [7:0] AsciiZero = 8'h30;
  localparam logic [7:0] AsciiA    = 8'h41;

  localparam int unsigned DefaultClksPerBit = 217;

  typedef enum logic [2:0] {
    RecIdle,
    RecHi,
    RecLo,
    RecCr,
    RecLf
  } rec_state_t;

  typedef enum logic [1:0] {
    SerIdle,
    SerStart,
    SerData,
    SerStop
  } ser_state_t;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] i_nib);
    if (i_nib < 4'd10) begin
      return AsciiZero + {4'd0, i_nib};
    end
    return AsciiA + {4'd0, i_nib} - 8'd10;
  endfunction

endpackage

// File: rtl/hex_tx_fifo.sv
// hex_tx_fifo: FIFO_DEPTH x 8 byte buffer with wrap-bit pointers.
//   i_Clk, i_Rst_L : clock, async active-low reset (empties the FIFO)
//   i_Push, i_Data : write one byte (ignored while full)
//   i_Pop          : drop the head entry (ignored while empty)
//   o_Data         : head entry, valid while o_Empty is low
//   o_Full/o_Empty : status from the registered pointers
module hex_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Push,
  input  logic [7:0] i_Data,
  input  logic       i_Pop,
  output logic [7:0] o_Data,
  output logic       o_Full,
  output logic       o_Empty
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  // Pointers carry one extra wrap bit: equal low bits with differing MSBs means full.
  assign o_Full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_Empty = (r_wr_ptr == r_rd_ptr);
  assign o_Data  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_do_push = i_Push && !o_Full;
  assign w_do_pop  = i_Pop && !o_Empty;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge i_Clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_Data;
  end

endmodule

// File: rtl/uart_hex_tx.sv
// uart_hex_tx: buffers bytes and sends each as two uppercase hex characters (plus optional
// CR LF) over 8N1 UART.
//   i_Clk, i_Rst_L        : clock, async active-low reset
//   i_Byte_DV, i_Byte     : byte handshake, accepted when i_Byte_DV && o_Ready
//   o_Ready               : FIFO not full
//   o_Overflow            : i_Byte_DV while full; byte dropped
//   o_TX_Serial           : UART line, idles high
//   o_TX_Active           : high while a record's characters are on the line
//   o_Char_Done           : pulse on the last stop-bit cycle of every character
module uart_hex_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          APPEND_CRLF  = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Byte_DV,
  input  logic [7:0] i_Byte,
  output logic       o_Ready,
  output logic       o_Overflow,
  output logic       o_TX_Serial,
  output logic       o_TX_Active,
  output logic       o_Char_Done
);

  localparam logic [15:0] BitCntMax = 16'(CLKS_PER_BIT - 1);

  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic [7:0] w_fifo_data;

  rec_state_t r_rec_state, w_rec_nxt, w_rec_after;
  ser_state_t r_ser_state, w_ser_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_bit_idx, w_bit_idx_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [7:0]  r_byte, w_byte_nxt;
  logic        r_tx_serial, w_tx_nxt;

  hex_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .i_Push (i_Byte_DV),
    .i_Data (i_Byte),
    .i_Pop  (w_pop),
    .o_Data (w_fifo_data),
    .o_Full (w_full),
    .o_Empty(w_empty)
  );

  assign o_Ready     = !w_full;
  assign o_Overflow  = i_Byte_DV && w_full;
  assign o_TX_Serial = r_tx_serial;
  assign o_TX_Active = (r_ser_state != SerIdle);
  assign o_Char_Done = (r_ser_state == SerStop) && (r_cnt == 16'd0);

  function automatic rec_state_t next_rec(input rec_state_t i_st);
    case (i_st)
      RecHi:   return RecLo;
      RecLo:   return APPEND_CRLF ? RecCr : RecIdle;
      RecCr:   return RecLf;
      default: return RecIdle;
    endcase
  endfunction

  function automatic logic [7:0] char_for(input rec_state_t i_st, input logic [7:0] i_b);
    case (i_st)
      RecHi:   return nibble_to_ascii(i_b[7:4]);
      RecLo:   return nibble_to_ascii(i_b[3:0]);
      RecCr:   return AsciiCr;
      default: return AsciiLf;
    endcase
  endfunction

  assign w_rec_after = next_rec(r_rec_state);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_rec_state <= RecIdle;
      r_ser_state <= SerIdle;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_byte      <= '0;
      r_tx_serial <= 1'b1;
    end else begin
      r_rec_state <= w_rec_nxt;
      r_ser_state <= w_ser_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_byte      <= w_byte_nxt;
      r_tx_serial <= w_tx_nxt;
    end
  end

  always_comb begin
    w_rec_nxt     = r_rec_state;
    w_ser_nxt     = r_ser_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_byte_nxt    = r_byte;
    w_tx_nxt      = r_tx_serial;
    w_pop         = 1'b0;

    unique case (r_ser_state)
      SerIdle: begin
        // Pop and launch the high-digit start bit on the same edge.
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_byte_nxt  = w_fifo_data;
          w_rec_nxt   = RecHi;
          w_ser_nxt   = SerStart;
          w_cnt_nxt   = BitCntMax;
          w_shift_nxt = char_for(RecHi, w_fifo_data);
          w_tx_nxt    = 1'b0;
        end
      end
      SerStart: begin
        if (r_cnt == 16'd0) begin
          w_ser_nxt     = SerData;
          w_cnt_nxt     = BitCntMax;
          w_bit_idx_nxt = 3'd0;
          w_tx_nxt      = r_shift[0];
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      SerData: begin
        if (r_cnt == 16'd0) begin
          w_cnt_nxt = BitCntMax;
          if (r_bit_idx == 3'd7) begin
            w_ser_nxt = SerStop;
            w_tx_nxt  = 1'b1;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_tx_nxt      = r_shift[r_bit_idx + 3'd1];
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      SerStop: begin
        if (r_cnt == 16'd0) begin
          w_rec_nxt = w_rec_after;
          if (w_rec_after != RecIdle) begin
            // Next character of the record starts with no gap.
            w_ser_nxt   = SerStart;
            w_cnt_nxt   = BitCntMax;
            w_shift_nxt = char_for(w_rec_after, r_byte);
            w_tx_nxt    = 1'b0;
          end else begin
            w_ser_nxt = SerIdle;
            w_tx_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_uart_hex_tx.sv
// tb_uart_hex_tx: directed/randomized bench for uart_hex_tx using three instances
// (0: 217 clks/bit CRLF, 1: 4 clks/bit CRLF, 2: 4 clks/bit no CRLF).
module tb_uart_hex_tx;

  logic       clk;
  logic       rst_n;
  logic       dv_a, dv_b, dv_c;
  logic [7:0] byte_in;
  logic       ready_a, ovf_a, ser_a, act_a, done_a;
  logic       ready_b, ovf_b, ser_b, act_b, done_b;
  logic       ready_c, ovf_c, ser_c, act_c, done_c;

  int checks   = 0;
  int failures = 0;

  uart_hex_tx #(.CLKS_PER_BIT(217), .FIFO_DEPTH(4), .APPEND_CRLF(1'b1)) u_dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Byte_DV(dv_a), .i_Byte(byte_in),
    .o_Ready(ready_a), .o_Overflow(ovf_a), .o_TX_Serial(ser_a), .o_TX_Active(act_a),
    .o_Char_Done(done_a)
  );

  uart_hex_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .APPEND_CRLF(1'b1)) u_dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Byte_DV(dv_b), .i_Byte(byte_in),
    .o_Ready(ready_b), .o_Overflow(ovf_b), .o_TX_Serial(ser_b), .o_TX_Active(act_b),
    .o_Char_Done(done_b)
  );

  uart_hex_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .APPEND_CRLF(1'b0)) u_dut_c (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Byte_DV(dv_c), .i_Byte(byte_in),
    .o_Ready(ready_c), .o_Overflow(ovf_c), .o_TX_Serial(ser_c), .o_TX_Active(act_c),
    .o_Char_Done(done_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic logic get_ser(input int d);
    case (d) 0: return ser_a; 1: return ser_b; default: return ser_c; endcase
  endfunction
  function automatic logic get_act(input int d);
    case (d) 0: return act_a; 1: return act_b; default: return act_c; endcase
  endfunction
  function automatic logic get_done(input int d);
    case (d) 0: return done_a; 1: return done_b; default: return done_c; endcase
  endfunction
  function automatic logic get_ready(input int d);
    case (d) 0: return ready_a; 1: return ready_b; default: return ready_c; endcase
  endfunction
  function automatic logic get_ovf(input int d);
    case (d) 0: return ovf_a; 1: return ovf_b; default: return ovf_c; endcase
  endfunction

  task automatic set_dv(input int d, input logic v);
    case (d) 0: dv_a = v; 1: dv_b = v; default: dv_c = v; endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called on the first start-bit cycle; returns on the cycle after the stop bit.
  task automatic check_char(input int d, input int cpb, input logic [7:0] ch, input string tag);
    int         bad = 0;
    int         done_bad = 0;
    logic       exp;
    logic [7:0] cap = '0;
    for (int i = 0; i < 10 * cpb; i++) begin
      int bitn = i / cpb;
      if (bitn == 0)      exp = 1'b0;
      else if (bitn == 9) exp = 1'b1;
      else                exp = ch[bitn-1];
      if (bitn >= 1 && bitn <= 8 && (i % cpb) == cpb / 2) cap[bitn-1] = get_ser(d);
      if (get_ser(d) !== exp || get_act(d) !== 1'b1) bad++;
      if (get_done(d) !== (i == 10 * cpb - 1)) done_bad++;
      tick();
    end
    checks++;
    assert (bad === 0) else begin
      failures++;
      $error("FAIL %s char: observed=0x%02h expected=0x%02h bad_cycles=%0d", tag, cap, ch, bad);
    end
    checks++;
    assert (done_bad === 0) else begin
      failures++;
      $error("FAIL %s char_done: bad_cycles=%0d expected 0", tag, done_bad);
    end
  endtask

  // Reference: byte -> hex text (+ CR LF) checked character by character.
  task automatic check_record(input int d, input int cpb, input logic [7:0] b, input bit crlf,
                              input string tag);
    string      hx = "0123456789ABCDEF";
    logic [7:0] q[$];
    q.push_back(8'(hx[int'(b[7:4])]));
    q.push_back(8'(hx[int'(b[3:0])]));
    if (crlf) begin
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
    foreach (q[i]) check_char(d, cpb, q[i], $sformatf("%s_c%0d", tag, i));
  endtask

  // Push one byte into an idle instance and step to its first start-bit cycle.
  task automatic push_start(input int d, input logic [7:0] b, input string tag);
    byte_in = b;
    set_dv(d, 1'b1);
    tick();
    set_dv(d, 1'b0);
    chk(get_act(d), 0, {tag, "_lat_not_yet"});
    chk(get_ser(d), 1, {tag, "_lat_line_high"});
    tick();
  endtask

  task automatic wait_idle(input int d, input int max, input string tag);
    int n = 0;
    while (get_act(d) === 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk(get_act(d), 0, {tag, "_wait_idle"});
  endtask

  initial begin
    logic [7:0] q6[6];
    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] ch1;
    string      hx = "0123456789ABCDEF";

    rst_n = 1'b0; dv_a = 1'b0; dv_b = 1'b0; dv_c = 1'b0; byte_in = '0;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      chk(get_ready(d), 1, $sformatf("rst%0d_ready", d));
      chk(get_ovf(d),   0, $sformatf("rst%0d_ovf", d));
      chk(get_ser(d),   1, $sformatf("rst%0d_ser", d));
      chk(get_act(d),   0, $sformatf("rst%0d_act", d));
      chk(get_done(d),  0, $sformatf("rst%0d_done", d));
    end
    rst_n = 1'b1;
    tick();

    // 0x41 at 217 clocks/bit: "41\r\n".
    push_start(0, 8'h41, "t1");
    check_record(0, 217, 8'h41, 1'b1, "t1");
    chk(act_a, 0, "t1_end_act");
    chk(ser_a, 1, "t1_end_ser");

    // Back-to-back records with one idle cycle between them.
    byte_in = 8'hAF; dv_b = 1'b1;
    tick();
    byte_in = 8'h09;
    tick();
    dv_b = 1'b0;
    check_record(1, 4, 8'hAF, 1'b1, "t2a");
    chk(act_b, 0, "t2_gap_act");
    chk(ser_b, 1, "t2_gap_ser");
    tick();
    check_record(1, 4, 8'h09, 1'b1, "t2b");
    chk(act_b, 0, "t2_end_act");

    // Burst of 6 into a depth-4 FIFO from idle: 5 accepted, 6th dropped.
    repeat (3) tick();
    for (int k = 0; k < 6; k++) q6[k] = 8'($urandom);
    for (int k = 0; k < 6; k++) begin
      byte_in = q6[k];
      dv_b = 1'b1;
      #1;
      chk(ovf_b,   (k == 5) ? 1 : 0, $sformatf("t3_ovf_%0d", k));
      chk(ready_b, (k < 5) ? 1 : 0,  $sformatf("t3_ready_%0d", k));
      tick();
    end
    dv_b = 1'b0;
    #1;
    chk(ovf_b, 0, "t3_ovf_after");
    chk(ready_b, 0, "t3_full_after");
    wait_idle(1, 400, "t3");
    chk(ready_b, 0, "t3_full_in_gap");
    for (int j = 1; j < 5; j++) begin
      chk(act_b, 0, $sformatf("t3_gap_%0d", j));
      tick();
      if (j == 1) chk(ready_b, 1, "t3_ready_after_pop");
      check_record(1, 4, q6[j], 1'b1, $sformatf("t3r%0d", j));
    end
    repeat (5) tick();
    chk(act_b, 0, "t3_sixth_dropped_act");
    chk(ser_b, 1, "t3_sixth_dropped_ser");

    // No CR LF: 0xFF then a random byte, 20 bit-times each.
    push_start(2, 8'hFF, "t4a");
    check_record(2, 4, 8'hFF, 1'b0, "t4a");
    chk(act_c, 0, "t4a_end_act");
    r0 = 8'($urandom);
    push_start(2, r0, "t4b");
    check_record(2, 4, r0, 1'b0, "t4b");
    chk(act_c, 0, "t4b_end_act");

    // Reset in the middle of data bit 2 of the second character.
    r0 = 8'($urandom);
    r1 = 8'($urandom);
    byte_in = r0; dv_b = 1'b1;
    tick();
    byte_in = r1;
    tick();
    byte_in = 8'($urandom);
    tick();
    dv_b = 1'b0;
    repeat (53) tick();
    ch1 = 8'(hx[int'(r0[3:0])]);
    chk(ser_b, ch1[2], "t5_pre_reset_bit");
    #2;
    rst_n = 1'b0;
    #1;
    chk(ser_b, 1, "t5_rst_ser");
    chk(act_b, 0, "t5_rst_act");
    chk(ready_b, 1, "t5_rst_ready");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk(act_b, 0, "t5_queue_lost");
    push_start(1, 8'h00, "t5");
    check_record(1, 4, 8'h00, 1'b1, "t5");

    // Exact 40-bit pattern for 0x5A, then random bytes.
    push_start(1, 8'h5A, "t6");
    check_record(1, 4, 8'h5A, 1'b1, "t6");
    for (int k = 0; k < 3; k++) begin
      r0 = 8'($urandom);
      tick();
      push_start(1, r0, $sformatf("t7_%0d", k));
      check_record(1, 4, r0, 1'b1, $sformatf("t7_%0d", k));
    end
    chk(act_b, 0, "t7_end_act");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
